// File: rtl/perceptron_btb_predictor.sv
// Perceptron direction predictor fused with a direct-mapped BTB; tables are swept clear by INIT.
// Define BP_STATS_EN to enable the saturating update/mispredict statistics counters.
module perceptron_btb_predictor #(
  parameter int ENTRIES  = 16,
  parameter int HIST_LEN = 8,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = 29
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  output logic                upd_ready,
  output logic [HIST_LEN-1:0] ghr,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
  localparam int WTS_W = HIST_LEN * WEIGHT_W;

  localparam logic signed [WEIGHT_W-1:0] W_MAX   = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN   = -W_MAX;
  localparam logic signed [WEIGHT_W-1:0] W_ONE   = 1;
  localparam logic signed [SUM_W-1:0]    THETA_S = SUM_W'(THETA);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic               pred_valid_q, pred_valid_d;
  logic               pred_hit_q, pred_hit_d;
  logic               pred_taken_q, pred_taken_d;
  logic [31:0]        pred_target_q, pred_target_d;

  logic                       valid_q  [ENTRIES];
  logic [TAG_W-1:0]           tag_q    [ENTRIES];
  logic [31:0]                target_q [ENTRIES];
  logic signed [WEIGHT_W-1:0] w0_q     [ENTRIES];
  logic [WTS_W-1:0]           wts_q    [ENTRIES];

  logic                       wr_en;
  logic [IDX_W-1:0]           wr_idx;
  logic                       wr_valid;
  logic [TAG_W-1:0]           wr_tag;
  logic [31:0]                wr_target;
  logic signed [WEIGHT_W-1:0] wr_w0;
  logic [WTS_W-1:0]           wr_wts;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] w);
    return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  function automatic logic signed [SUM_W-1:0] calc_y(
    input logic signed [WEIGHT_W-1:0] bias,
    input logic [WTS_W-1:0]           wts,
    input logic [HIST_LEN-1:0]        hist
  );
    logic signed [SUM_W-1:0] acc;
    acc = sext(bias);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (hist[i]) acc = acc + sext(wts[i*WEIGHT_W +: WEIGHT_W]);
      else         acc = acc - sext(wts[i*WEIGHT_W +: WEIGHT_W]);
    end
    return acc;
  endfunction

  function automatic logic signed [WEIGHT_W-1:0] sat_step(
    input logic signed [WEIGHT_W-1:0] w,
    input logic                       up
  );
    if (up) return (w == W_MAX) ? w : w + W_ONE;
    return (w == W_MIN) ? w : w - W_ONE;
  endfunction

  logic [IDX_W-1:0]        lk_idx, up_idx;
  logic [TAG_W-1:0]        lk_tag, up_tag;
  logic                    lk_hit, lk_taken, up_hit, up_dir, train, accept;
  logic signed [SUM_W-1:0] lk_y, up_y;
  logic                    unused_pc_bits;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[31:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_y     = calc_y(w0_q[lk_idx], wts_q[lk_idx], ghr_q);
  assign lk_taken = lk_hit && !lk_y[SUM_W-1];

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_y   = calc_y(w0_q[up_idx], wts_q[up_idx], ghr_q);
  assign up_dir = !up_y[SUM_W-1];
  assign train  = (up_dir != upd_taken) || ((up_y <= THETA_S) && (up_y >= -THETA_S));
  assign accept = upd_valid && (state_q == RUN) && !flush;

  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // The INIT sweep owns the write port; otherwise an accepted update writes its row.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = init_cnt_q;
    wr_valid  = 1'b0;
    wr_tag    = '0;
    wr_target = '0;
    wr_w0     = '0;
    wr_wts    = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (accept && (up_hit || upd_taken)) begin
      wr_en     = 1'b1;
      wr_idx    = up_idx;
      wr_valid  = valid_q[up_idx] | upd_taken;
      wr_tag    = upd_taken ? up_tag : tag_q[up_idx];
      wr_target = upd_taken ? upd_target : target_q[up_idx];
      wr_w0     = w0_q[up_idx];
      wr_wts    = wts_q[up_idx];
      if (train) begin
        wr_w0 = sat_step(w0_q[up_idx], upd_taken);
        for (int i = 0; i < HIST_LEN; i++) begin
          wr_wts[i*WEIGHT_W +: WEIGHT_W] =
            sat_step(wts_q[up_idx][i*WEIGHT_W +: WEIGHT_W], upd_taken == ghr_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      w0_q[wr_idx]     <= wr_w0;
      wts_q[wr_idx]    <= wr_wts;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    ghr_d         = ghr_q;
    pred_valid_d  = lookup_valid && (state_q == RUN) && !flush;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
    end
    if (accept) ghr_d = (ghr_q << 1) | HIST_LEN'(upd_taken);
    if (pred_valid_d) begin
      pred_hit_d    = lk_hit;
      pred_taken_d  = lk_taken;
      pred_target_d = lk_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
    end
    if (flush) begin
      state_d    = INIT;
      init_cnt_d = '0;
      ghr_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      ghr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      ghr_q         <= ghr_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign upd_ready   = (state_q == RUN);
  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign ghr         = ghr_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;
  logic        mispredict;

  // Target mismatch only matters for taken branches; the direction check covers the rest.
  assign mispredict = ((up_hit && up_dir) != upd_taken) ||
                      (upd_taken && (target_q[up_idx] != upd_target));

  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept && (stat_updates_q != '1)) stat_updates_d = stat_updates_q + 32'd1;
    if (accept && mispredict && (stat_mispredicts_q != '1))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
